// File: rtl/hangman_engine.sv
// hangman_engine: parametrised blind-hangman game engine.
// The word ROM is external: the engine drives word_addr and samples word_data
// one cycle later in LOAD. Each guess is checked against every letter
// position in a single CHECK cycle. A guess that was already used, or that
// equals the pad code, is flagged and costs no try.
module hangman_engine #(
    parameter int               WORD_LEN  = 5,
    parameter int               CHAR_W    = 5,
    parameter int               MAX_TRIES = 7,
    parameter int               IDX_W     = 6,
    parameter logic [CHAR_W-1:0] PAD      = {CHAR_W{1'b1}},
    localparam int              TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [IDX_W-1:0]           word_sel,
    output logic [IDX_W-1:0]           word_addr,
    input  logic [WORD_LEN*CHAR_W-1:0] word_data,
    input  logic                       guess_valid,
    input  logic [CHAR_W-1:0]          guess_char,
    output logic                       guess_ready,
    output logic [WORD_LEN-1:0]        revealed,
    output logic [TRY_W-1:0]           tries,
    output logic                       hit,
    output logic                       repeat_guess,
    output logic                       win,
    output logic                       lose
);

    localparam int ALPHA = 2 ** CHAR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GUESS = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    // Bit b of the result flags the character field at word[b*CHAR_W +: CHAR_W],
    // so bit WORD_LEN-1 is letter position 0 (MSB field of the word).
    function automatic logic [WORD_LEN-1:0] pad_mask(
        input logic [WORD_LEN*CHAR_W-1:0] w
    );
        logic [WORD_LEN-1:0] m;
        m = {WORD_LEN{1'b0}};
        for (int b = 0; b < WORD_LEN; b++) begin
            m[b] = (w[b*CHAR_W +: CHAR_W] == PAD);
        end
        return m;
    endfunction

    // Positions equal to the guess that are not yet revealed.
    function automatic logic [WORD_LEN-1:0] match_mask(
        input logic [WORD_LEN*CHAR_W-1:0] w,
        input logic [CHAR_W-1:0]          g,
        input logic [WORD_LEN-1:0]        rev
    );
        logic [WORD_LEN-1:0] m;
        m = {WORD_LEN{1'b0}};
        for (int b = 0; b < WORD_LEN; b++) begin
            m[b] = (w[b*CHAR_W +: CHAR_W] == g) & ~rev[b];
        end
        return m;
    endfunction

    // Registered state
    state_t                      state_r;
    logic                        start_prev_r;
    logic [IDX_W-1:0]            word_addr_r;
    logic [WORD_LEN*CHAR_W-1:0]  word_r;
    logic [CHAR_W-1:0]           guess_r;
    logic [ALPHA-1:0]            used_r;
    logic [WORD_LEN-1:0]         revealed_r;
    logic [TRY_W-1:0]            tries_r;
    logic                        hit_r;
    logic                        repeat_r;
    logic                        win_r;
    logic                        lose_r;
    logic                        guess_ready_r;

    // Next-state values
    state_t                      state_s;
    logic [IDX_W-1:0]            word_addr_s;
    logic [WORD_LEN*CHAR_W-1:0]  word_s;
    logic [CHAR_W-1:0]           guess_s;
    logic [ALPHA-1:0]            used_s;
    logic [WORD_LEN-1:0]         revealed_s;
    logic [TRY_W-1:0]            tries_s;
    logic                        hit_s;
    logic                        repeat_s;

    logic                        start_edge_s;
    logic [WORD_LEN-1:0]         match_s;
    logic [WORD_LEN-1:0]         merged_s;
    logic [TRY_W-1:0]            tries_inc_s;

    assign start_edge_s = start & ~start_prev_r;
    assign match_s      = match_mask(word_r, guess_r, revealed_r);
    assign merged_s     = revealed_r | match_s;
    assign tries_inc_s  = tries_r + TRY_W'(32'd1);

    // Next-state and datapath update; abort overrides every other input.
    always_comb begin
        state_s     = state_r;
        word_addr_s = word_addr_r;
        word_s      = word_r;
        guess_s     = guess_r;
        used_s      = used_r;
        revealed_s  = revealed_r;
        tries_s     = tries_r;
        hit_s       = 1'b0;
        repeat_s    = 1'b0;

        if (abort) begin
            state_s     = S_IDLE;
            word_addr_s = {IDX_W{1'b0}};
            word_s      = {(WORD_LEN*CHAR_W){1'b0}};
            guess_s     = {CHAR_W{1'b0}};
            used_s      = {ALPHA{1'b0}};
            revealed_s  = {WORD_LEN{1'b0}};
            tries_s     = {TRY_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    word_s     = {(WORD_LEN*CHAR_W){1'b0}};
                    guess_s    = {CHAR_W{1'b0}};
                    used_s     = {ALPHA{1'b0}};
                    revealed_s = {WORD_LEN{1'b0}};
                    tries_s    = {TRY_W{1'b0}};
                    if (start_edge_s) begin
                        word_addr_s = word_sel;
                        state_s     = S_LOAD;
                    end else begin
                        word_addr_s = {IDX_W{1'b0}};
                    end
                end
                S_LOAD: begin
                    word_s     = word_data;
                    revealed_s = pad_mask(word_data);
                    if (&pad_mask(word_data)) begin
                        state_s = S_WIN;
                    end else begin
                        state_s = S_GUESS;
                    end
                end
                S_GUESS: begin
                    // guess_ready is high throughout GUESS, so valid alone completes the transfer.
                    if (guess_valid) begin
                        guess_s = guess_char;
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_GUESS;
                    end
                end
                S_CHECK: begin
                    if (used_r[guess_r] || (guess_r == PAD)) begin
                        repeat_s = 1'b1;
                        state_s  = S_GUESS;
                    end else begin
                        used_s[guess_r] = 1'b1;
                        if (|match_s) begin
                            revealed_s = merged_s;
                            hit_s      = 1'b1;
                            if (&merged_s) begin
                                state_s = S_WIN;
                            end else begin
                                state_s = S_GUESS;
                            end
                        end else begin
                            // Saturating guard; tries is below MAX_TRIES in any reachable CHECK.
                            if (tries_r < TRY_W'(MAX_TRIES)) begin
                                tries_s = tries_inc_s;
                            end else begin
                                tries_s = tries_r;
                            end
                            if (tries_inc_s >= TRY_W'(MAX_TRIES)) begin
                                state_s = S_LOSE;
                            end else begin
                                state_s = S_GUESS;
                            end
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start_edge_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s     = S_IDLE;
                    word_addr_s = {IDX_W{1'b0}};
                    word_s      = {(WORD_LEN*CHAR_W){1'b0}};
                    guess_s     = {CHAR_W{1'b0}};
                    used_s      = {ALPHA{1'b0}};
                    revealed_s  = {WORD_LEN{1'b0}};
                    tries_s     = {TRY_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and registered outputs; results are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            start_prev_r  <= 1'b0;
            word_addr_r   <= {IDX_W{1'b0}};
            word_r        <= {(WORD_LEN*CHAR_W){1'b0}};
            guess_r       <= {CHAR_W{1'b0}};
            used_r        <= {ALPHA{1'b0}};
            revealed_r    <= {WORD_LEN{1'b0}};
            tries_r       <= {TRY_W{1'b0}};
            hit_r         <= 1'b0;
            repeat_r      <= 1'b0;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            guess_ready_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            start_prev_r  <= start;
            word_addr_r   <= word_addr_s;
            word_r        <= word_s;
            guess_r       <= guess_s;
            used_r        <= used_s;
            revealed_r    <= revealed_s;
            tries_r       <= tries_s;
            hit_r         <= hit_s;
            repeat_r      <= repeat_s;
            win_r         <= (state_s == S_WIN);
            lose_r        <= (state_s == S_LOSE);
            guess_ready_r <= (state_s == S_GUESS);
        end
    end

    assign word_addr    = word_addr_r;
    assign guess_ready  = guess_ready_r;
    assign revealed     = revealed_r;
    assign tries        = tries_r;
    assign hit          = hit_r;
    assign repeat_guess = repeat_r;
    assign win          = win_r;
    assign lose         = lose_r;

endmodule

// File: tb/tb_hangman_engine.sv
// Directed testbench for hangman_engine with a small behavioural word ROM.
module tb_hangman_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [5:0]  word_sel;
    logic [5:0]  word_addr;
    logic [24:0] word_data;
    logic        guess_valid;
    logic [4:0]  guess_char;
    logic        guess_ready;
    logic [4:0]  revealed;
    logic [2:0]  tries;
    logic        hit;
    logic        repeat_guess;
    logic        win;
    logic        lose;

    int n_total;
    int n_bad;

    hangman_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .word_sel     (word_sel),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .guess_valid  (guess_valid),
        .guess_char   (guess_char),
        .guess_ready  (guess_ready),
        .revealed     (revealed),
        .tries        (tries),
        .hit          (hit),
        .repeat_guess (repeat_guess),
        .win          (win),
        .lose         (lose)
    );

    // Word ROM: 5 = HELLO, 9 = {2,0,19,PAD,PAD}, 33 = all PAD.
    always_comb begin
        case (word_addr)
            6'd5:    word_data = {5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
            6'd9:    word_data = {5'd2, 5'd0, 5'd19, 5'd31, 5'd31};
            6'd33:   word_data = {25{1'b1}};
            default: word_data = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [5:0] sel);
        word_sel = sel;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
    endtask

    task automatic do_guess(input logic [4:0] g);
        guess_valid = 1'b1;
        guess_char  = g;
        step();
        guess_valid = 1'b0;
        step();
    endtask

    task automatic to_idle();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},  32'(word_addr),    32'd0);
        check({tag, ".rev"},   32'(revealed),     32'd0);
        check({tag, ".tries"}, 32'(tries),        32'd0);
        check({tag, ".hit"},   32'(hit),          32'd0);
        check({tag, ".rep"},   32'(repeat_guess), 32'd0);
        check({tag, ".win"},   32'(win),          32'd0);
        check({tag, ".lose"},  32'(lose),         32'd0);
        check({tag, ".rdy"},   32'(guess_ready),  32'd0);
    endtask

    initial begin
        logic [4:0] wrong [7];
        wrong = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd8};
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        word_sel    = 6'd0;
        guess_valid = 1'b0;
        guess_char  = 5'd0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Test 1/4/2: HELLO, hit, repeats, then win
        start_game(6'd5);
        check("load.addr", 32'(word_addr), 32'd5);
        check("load.rev", 32'(revealed), 32'd0);
        check("load.rdy", 32'(guess_ready), 32'd1);
        do_guess(5'd11);
        check("g11.rev", 32'(revealed), 32'b00110);
        check("g11.hit", 32'(hit), 32'd1);
        check("g11.tries", 32'(tries), 32'd0);
        check("g11.rdy", 32'(guess_ready), 32'd1);
        step();
        check("g11.hitpulse", 32'(hit), 32'd0);
        do_guess(5'd11);
        check("rep11.rep", 32'(repeat_guess), 32'd1);
        check("rep11.hit", 32'(hit), 32'd0);
        check("rep11.tries", 32'(tries), 32'd0);
        check("rep11.rev", 32'(revealed), 32'b00110);
        do_guess(5'd31);
        check("pad.rep", 32'(repeat_guess), 32'd1);
        check("pad.tries", 32'(tries), 32'd0);
        do_guess(5'd7);
        check("g7.rev", 32'(revealed), 32'b10110);
        check("g7.rep", 32'(repeat_guess), 32'd0);
        do_guess(5'd4);
        check("g4.rev", 32'(revealed), 32'b11110);
        check("g4.win", 32'(win), 32'd0);
        do_guess(5'd14);
        check("g14.rev", 32'(revealed), 32'b11111);
        check("g14.win", 32'(win), 32'd1);
        check("g14.lose", 32'(lose), 32'd0);
        check("g14.rdy", 32'(guess_ready), 32'd0);
        to_idle();
        check("win2idle.win", 32'(win), 32'd0);
        check("win2idle.rev", 32'(revealed), 32'd0);

        // Test 3: seven misses -> lose
        start_game(6'd5);
        for (int k = 0; k < 7; k++) begin
            do_guess(wrong[k]);
            check($sformatf("miss%0d.tries", k), 32'(tries), 32'(k + 1));
            check($sformatf("miss%0d.lose", k), 32'(lose), (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("miss%0d.rev", k), 32'(revealed), 32'd0);
        end
        check("lose.win", 32'(win), 32'd0);
        do_guess(5'd9);
        check("lose.frozen", 32'(tries), 32'd7);
        check("lose.rdy", 32'(guess_ready), 32'd0);
        to_idle();
        check("lose2idle.lose", 32'(lose), 32'd0);

        // Test 5: padded word and all-pad word
        start_game(6'd9);
        check("pad.load.rev", 32'(revealed), 32'b00011);
        do_guess(5'd2);
        check("pad.g2.rev", 32'(revealed), 32'b10011);
        do_guess(5'd0);
        check("pad.g0.rev", 32'(revealed), 32'b11011);
        check("pad.g0.win", 32'(win), 32'd0);
        do_guess(5'd19);
        check("pad.g19.win", 32'(win), 32'd1);
        to_idle();
        start_game(6'd33);
        check("allpad.win", 32'(win), 32'd1);
        check("allpad.rev", 32'(revealed), 32'b11111);
        check("allpad.rdy", 32'(guess_ready), 32'd0);
        to_idle();

        // Test 6a: abort together with guess_valid in GUESS
        start_game(6'd5);
        do_guess(5'd11);
        abort       = 1'b1;
        guess_valid = 1'b1;
        guess_char  = 5'd7;
        step();
        abort       = 1'b0;
        guess_valid = 1'b0;
        check_all_zero("abort");
        step();
        check("abort.stay", 32'(guess_ready), 32'd0);

        // Test 6b: async reset while in CHECK
        start_game(6'd5);
        do_guess(5'd11);
        guess_valid = 1'b1;
        guess_char  = 5'd7;
        step();
        guess_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        step();
        reset = 1'b1;
        step();
        check("arst.idle", 32'(guess_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
